// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between NUM_REQ
// requesters, with a registered operand stage and a one-entry response buffer per
// requester. Optional per-requester grant/stall counters are built when the macro
// ALU_SHARE_ARBITER_PERF_EN is defined.
module alu_share_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XLEN-1:0] req_d0,
    input  logic [NUM_REQ*XLEN-1:0] req_d1,
    input  logic [NUM_REQ*4-1:0]    req_op,
    input  logic [NUM_REQ-1:0]      req_word,
    output logic [NUM_REQ-1:0]      resp_valid,
    input  logic [NUM_REQ-1:0]      resp_ready,
    output logic [NUM_REQ*XLEN-1:0] resp_y,
    output logic [XLEN-1:0]         alu_d0,
    output logic [XLEN-1:0]         alu_d1,
    output logic [3:0]              alu_s,
    output logic                    alu_is_word_op,
    input  logic [XLEN-1:0]         alu_y
`ifdef ALU_SHARE_ARBITER_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]   perf_grant_cnt,
    output logic [NUM_REQ*32-1:0]   perf_stall_cnt
`endif
);

    localparam int unsigned OPW = 4;
    localparam int unsigned CNTW = 32;

    logic [NUM_REQ-1:0] buf_full;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               stage_vld;
    logic [IDW-1:0]     stage_id;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     scan_idx;
    logic [IDW-1:0]     win_id;
    logic               win_vld;
    logic [XLEN-1:0]    win_d0;
    logic [XLEN-1:0]    win_d1;
    logic [OPW-1:0]     win_op;
    logic               win_word;

    // A requester may issue when its buffer is free (or draining now) and it has nothing in the ALU stage.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = rst_n & req_valid[i] & (~buf_full[i] | resp_ready[i])
                        & ~(stage_vld & (stage_id == IDW'(i)));
        end
    end

    // Round-robin search upward from rr_ptr with wrap; first eligible requester wins.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((32'(rr_ptr) + 32'(k)) % NUM_REQ);
            if (!win_vld && eligible[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    // One-hot grant and selection of the winner's operands.
    always_comb begin
        grant    = '0;
        win_d0   = '0;
        win_d1   = '0;
        win_op   = '0;
        win_word = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_vld && (win_id == IDW'(i))) begin
                grant[i] = 1'b1;
                win_d0   = req_d0[i*XLEN +: XLEN];
                win_d1   = req_d1[i*XLEN +: XLEN];
                win_op   = req_op[i*OPW +: OPW];
                win_word = req_word[i];
            end
        end
    end

    assign req_ready  = grant;
    assign resp_valid = buf_full;

    // Stage A: register the winner onto the ALU inputs; hold them when idle to avoid toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld      <= 1'b0;
            stage_id       <= '0;
            rr_ptr         <= '0;
            alu_d0         <= '0;
            alu_d1         <= '0;
            alu_s          <= '0;
            alu_is_word_op <= 1'b0;
        end else begin
            stage_vld <= win_vld;
            if (win_vld) begin
                stage_id       <= win_id;
                rr_ptr         <= IDW'((32'(win_id) + 32'd1) % NUM_REQ);
                alu_d0         <= win_d0;
                alu_d1         <= win_d1;
                alu_s          <= win_op;
                alu_is_word_op <= win_word;
            end
        end
    end

    // Stage B: capture the ALU result into the owner's buffer; a write wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= '0;
            resp_y   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stage_vld && (stage_id == IDW'(i))) begin
                    resp_y[i*XLEN +: XLEN] <= alu_y;
                    buf_full[i]            <= 1'b1;
                end else if (buf_full[i] && resp_ready[i]) begin
                    buf_full[i] <= 1'b0;
                end
            end
        end
    end

`ifdef ALU_SHARE_ARBITER_PERF_EN
    // Per-requester grant and stall counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    perf_grant_cnt[i*CNTW +: CNTW] <= perf_grant_cnt[i*CNTW +: CNTW] + 32'd1;
                end
                if (req_valid[i] && !grant[i]) begin
                    perf_stall_cnt[i*CNTW +: CNTW] <= perf_stall_cnt[i*CNTW +: CNTW] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter (XLEN=64, NUM_REQ=2) with a behavioural ALU
// attached and a per-requester scoreboard of expected results.
module tb_alu_share_arbiter;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned SHW     = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*XLEN-1:0] req_d0;
    logic [NUM_REQ*XLEN-1:0] req_d1;
    logic [NUM_REQ*4-1:0]    req_op;
    logic [NUM_REQ-1:0]      req_word;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [NUM_REQ-1:0]      resp_ready;
    logic [NUM_REQ*XLEN-1:0] resp_y;
    logic [XLEN-1:0]         alu_d0;
    logic [XLEN-1:0]         alu_d1;
    logic [3:0]              alu_s;
    logic                    alu_is_word_op;
    logic [XLEN-1:0]         alu_y;

    logic [XLEN-1:0] exp_q [NUM_REQ][$];
    int grant_cnt [NUM_REQ];
    int resp_cnt  [NUM_REQ];
    int checks = 0;
    int passed = 0;

    alu_share_arbiter #(.XLEN(XLEN), .NUM_REQ(NUM_REQ)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_d0         (req_d0),
        .req_d1         (req_d1),
        .req_op         (req_op),
        .req_word       (req_word),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_y         (resp_y),
        .alu_d0         (alu_d0),
        .alu_d1         (alu_d1),
        .alu_s          (alu_s),
        .alu_is_word_op (alu_is_word_op),
        .alu_y          (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU behaviour: word ops work on the low 32 bits and sign-extend.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b, input logic w);
        logic [XLEN-1:0] r;
        logic [31:0]     r32;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = XLEN'($signed(a) < $signed(b));
            OP_SLTU: r = XLEN'(a < b);
            OP_SLL:  r = a << b[SHW-1:0];
            OP_SRL:  r = a >> b[SHW-1:0];
            OP_SRA:  r = XLEN'($signed(a) >>> b[SHW-1:0]);
            default: r = '0;
        endcase
        case (op)
            OP_ADD:  r32 = a[31:0] + b[31:0];
            OP_SUB:  r32 = a[31:0] - b[31:0];
            OP_SLL:  r32 = a[31:0] << b[4:0];
            OP_SRL:  r32 = a[31:0] >> b[4:0];
            OP_SRA:  r32 = 32'($signed(a[31:0]) >>> b[4:0]);
            default: r32 = r[31:0];
        endcase
        if (w) r = {{(XLEN-32){r32[31]}}, r32};
        return r;
    endfunction

    // Shared ALU attached to the arbiter.
    always_comb alu_y = ref_alu(alu_s, alu_d0, alu_d1, alu_is_word_op);

    function automatic logic [XLEN-1:0] ry(input int i);
        return resp_y[i*XLEN +: XLEN];
    endfunction

    // Scoreboard: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin : sb
        logic [XLEN-1:0] want;
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    checks++;
                    resp_cnt[i]++;
                    if (exp_q[i].size() == 0) begin
                        $display("FAIL sb_extra_resp%0d got=%h required=none", i, ry(i));
                    end else begin
                        want = exp_q[i].pop_front();
                        if (ry(i) !== want) $display("FAIL sb_resp%0d got=%h required=%h", i, ry(i), want);
                        else passed++;
                    end
                end
                if (req_valid[i] && req_ready[i]) begin
                    grant_cnt[i]++;
                    exp_q[i].push_back(ref_alu(req_op[i*4 +: 4], req_d0[i*XLEN +: XLEN],
                                               req_d1[i*XLEN +: XLEN], req_word[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int i, input logic [3:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic w);
        req_valid[i]           = 1'b1;
        req_op[i*4 +: 4]       = op;
        req_d0[i*XLEN +: XLEN] = a;
        req_d1[i*XLEN +: XLEN] = b;
        req_word[i]            = w;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        resp_ready = '0;
        req_word   = '0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_valid = '0; resp_ready = '0; req_word = '0;
        req_d0 = '0; req_d1 = '0; req_op = '0;
        #1 rst_n = 1'b0;
        req_valid = '1;
        #2;
        checks++; if (resp_valid !== 2'b00) $display("FAIL rst_resp_valid got=%b required=00", resp_valid); else passed++;
        checks++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready got=%b required=00", req_ready); else passed++;
        checks++; if ({alu_d0, alu_d1, alu_s, alu_is_word_op} !== '0)
            $display("FAIL rst_alu got=%h/%h/%h/%b required=0", alu_d0, alu_d1, alu_s, alu_is_word_op); else passed++;
        checks++; if (resp_y !== '0) $display("FAIL rst_resp_y got=%h required=0", resp_y); else passed++;
        tick();
        tick();
        checks++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready_held got=%b required=00", req_ready); else passed++;
        req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        resp_ready = 2'b01;
        drive(0, OP_ADD, 5, 7, 1'b0);
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL single_ready got=%b required=01", req_ready); else passed++;
        tick();
        req_valid = '0;
        #1;
        checks++; if (alu_s !== OP_ADD || alu_d0 !== 64'd5 || alu_d1 !== 64'd7)
            $display("FAIL single_stage_a got=%h/%h/%h required=0/5/7", alu_s, alu_d0, alu_d1); else passed++;
        checks++; if (resp_valid[0] !== 1'b0) $display("FAIL single_early_valid got=%b required=0", resp_valid[0]); else passed++;
        tick();
        #1;
        checks++; if (resp_valid[0] !== 1'b1 || ry(0) !== 64'd12)
            $display("FAIL single_resp got=%b/%h required=1/c", resp_valid[0], ry(0)); else passed++;
        tick();
        #1;
        checks++; if (resp_valid !== 2'b00) $display("FAIL single_consumed got=%b required=00", resp_valid); else passed++;
        resp_ready = '0;
    endtask

    task automatic test_alternate();
        int g0, g1, r0, r1;
        logic [1:0] want;
        do_reset();
        resp_ready = 2'b11;
        g0 = grant_cnt[0]; g1 = grant_cnt[1]; r0 = resp_cnt[0]; r1 = resp_cnt[1];
        drive(0, OP_SUB, 10, 3, 1'b0);
        drive(1, OP_XOR, 64'hF0, 64'h0F, 1'b0);
        for (int c = 0; c < 6; c++) begin
            want = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (req_ready !== want) $display("FAIL alt_grant%0d got=%b required=%b", c, req_ready, want); else passed++;
            tick();
        end
        req_valid = '0;
        tick(); tick(); tick();
        checks++; if (grant_cnt[0] - g0 != 3 || grant_cnt[1] - g1 != 3)
            $display("FAIL alt_grant_cnt got=%0d/%0d required=3/3", grant_cnt[0] - g0, grant_cnt[1] - g1); else passed++;
        checks++; if (resp_cnt[0] - r0 != 3 || resp_cnt[1] - r1 != 3)
            $display("FAIL alt_resp_cnt got=%0d/%0d required=3/3", resp_cnt[0] - r0, resp_cnt[1] - r1); else passed++;
        checks++; if (ry(0) !== 64'd7 || ry(1) !== 64'hFF)
            $display("FAIL alt_values got=%h/%h required=7/ff", ry(0), ry(1)); else passed++;
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        int n0;
        bit got;
        do_reset();
        resp_ready = 2'b01;
        drive(1, OP_OR, 64'hA0, 64'h05, 1'b0);
        #1;
        checks++; if (req_ready !== 2'b10) $display("FAIL bp_first_ready got=%b required=10", req_ready); else passed++;
        tick();
        req_valid = '0;
        tick();
        #1;
        checks++; if (resp_valid[1] !== 1'b1 || ry(1) !== 64'hA5)
            $display("FAIL bp_held got=%b/%h required=1/a5", resp_valid[1], ry(1)); else passed++;
        drive(1, OP_AND, 64'hFF, 64'h3C, 1'b0);
        drive(0, OP_ADD, 100, 23, 1'b0);
        n0 = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (req_ready[1] !== 1'b0) $display("FAIL bp_blocked%0d got=%b required=0", c, req_ready[1]); else passed++;
            checks++; if (resp_valid[1] !== 1'b1 || ry(1) !== 64'hA5)
                $display("FAIL bp_stable%0d got=%b/%h required=1/a5", c, resp_valid[1], ry(1)); else passed++;
            if (req_ready[0]) n0++;
            tick();
        end
        checks++; if (n0 != 3) $display("FAIL bp_req0_grants got=%0d required=3", n0); else passed++;
        resp_ready[1] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (req_ready[1]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!got) $display("FAIL bp_release got=timeout required=req_ready1"); else passed++;
        tick();
        req_valid = '0;
        tick(); tick(); tick();
        checks++; if (ry(1) !== 64'h3C || resp_valid !== 2'b00)
            $display("FAIL bp_drain got=%h/%b required=3c/00", ry(1), resp_valid); else passed++;
        resp_ready = '0;
    endtask

    task automatic test_drain_refill();
        do_reset();
        drive(0, OP_ADD, 1, 1, 1'b0);
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        checks++; if (resp_valid[0] !== 1'b1 || ry(0) !== 64'd2)
            $display("FAIL dr_held got=%b/%h required=1/2", resp_valid[0], ry(0)); else passed++;
        resp_ready[0] = 1'b1;
        drive(0, OP_SLL, 1, 4, 1'b0);
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL dr_accept got=%b required=01", req_ready); else passed++;
        tick();
        req_valid = '0;
        resp_ready = '0;
        tick();
        #1;
        checks++; if (resp_valid[0] !== 1'b1 || ry(0) !== 64'd16)
            $display("FAIL dr_refill got=%b/%h required=1/10", resp_valid[0], ry(0)); else passed++;
        resp_ready[0] = 1'b1;
        tick();
        #1;
        checks++; if (resp_valid[0] !== 1'b0) $display("FAIL dr_final got=%b required=0", resp_valid[0]); else passed++;
        resp_ready = '0;
    endtask

    task automatic test_word_op();
        do_reset();
        drive(0, OP_ADD, 64'h7FFF_FFFF, 64'd1, 1'b1);
        tick();
        req_valid = '0;
        #1;
        checks++; if (alu_is_word_op !== 1'b1 || alu_s !== OP_ADD)
            $display("FAIL word_stage_a got=%b/%h required=1/0", alu_is_word_op, alu_s); else passed++;
        tick();
        #1;
        checks++; if (ry(0) !== 64'hFFFF_FFFF_8000_0000)
            $display("FAIL word_result got=%h required=ffffffff80000000", ry(0)); else passed++;
        resp_ready[0] = 1'b1;
        drive(1, 4'hF, 3, 4, 1'b0);
        tick();
        req_valid = '0;
        req_word = '0;
        resp_ready[0] = 1'b0;
        #1;
        checks++; if (alu_s !== 4'hF) $display("FAIL illegal_op_fwd got=%h required=f", alu_s); else passed++;
        tick();
        #1;
        checks++; if (resp_valid[1] !== 1'b1 || ry(1) !== 64'd0)
            $display("FAIL illegal_op_result got=%b/%h required=1/0", resp_valid[1], ry(1)); else passed++;
        resp_ready = 2'b11;
        tick();
        resp_ready = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, OP_SUB, 50, 8, 1'b0);
        tick();
        req_valid = '0;
        tick();
        #1;
        checks++; if (resp_valid !== 2'b10) $display("FAIL ar_pre got=%b required=10", resp_valid); else passed++;
        drive(0, OP_ADD, 9, 9, 1'b0);
        tick();
        req_valid = '0;
        #1 rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if (resp_valid !== 2'b00) $display("FAIL ar_resp_valid got=%b required=00", resp_valid); else passed++;
        checks++; if (alu_s !== 4'd0 || alu_d0 !== '0 || alu_d1 !== '0)
            $display("FAIL ar_alu got=%h/%h/%h required=0", alu_s, alu_d0, alu_d1); else passed++;
        checks++; if (req_ready !== 2'b00) $display("FAIL ar_req_ready got=%b required=00", req_ready); else passed++;
        tick();
        tick();
        checks++; if (resp_valid !== 2'b00) $display("FAIL ar_no_replay got=%b required=00", resp_valid); else passed++;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) $display("FAIL ar_first_grant got=%b required=01", req_ready); else passed++;
        tick();
        req_valid = '0;
        resp_ready = 2'b11;
        tick(); tick(); tick();
        checks++; if (ry(0) !== 64'd18) $display("FAIL ar_after got=%h required=12", ry(0)); else passed++;
        resp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_alternate();
        test_backpressure();
        test_drain_refill();
        test_word_op();
        test_async_reset();
        tick();
        checks++; if (exp_q[0].size() != 0 || exp_q[1].size() != 0)
            $display("FAIL sb_leftover got=%0d/%0d required=0/0", exp_q[0].size(), exp_q[1].size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
